lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Initiator side of the data-memory port: sits in the MEM stage between the pipeline and the 16 KB data memory.
- Translates RISC-V load/store requests (funct3, 32-bit address, store data) into memory op_code/rwaddr/wdata/stall.
- Checks alignment and range, then aligns and sign/zero-extends the returned word.
- Returns results with the destination register tag; a two-state FSM tracks the outstanding load.

Parameters:
ADDR_W, 14, memory byte-address width; legal addresses are 0 .. 2^ADDR_W-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  MEM-stage access present
req_load  input  1  access is a load
req_store  input  1  access is a store
req_funct3  input  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
req_rd  input  5  load destination register
pipe_stall  input  1  global pipeline stall
req_ready  output  1  request accepted this cycle
op_code  output  3  to memory: 000 rd byte, 001 rd half, 010 rd word, 100 wr byte, 101 wr half, 111 wr word, 011 idle
rwaddr  output  ADDR_W  to memory: byte address
wdata  output  32  to memory: right-justified store data
stall  output  1  to memory: hold read output
rdata  input  32  from memory: aligned word, valid the cycle after a read is sampled
load_valid  output  1  one-cycle pulse, load result ready
load_data  output  32  extended load result
load_rd  output  5  tag of load_data
exc_valid  output  1  one-cycle exception pulse
exc_cause  output  2  01 misaligned, 10 out of range, 11 bad op
fault_addr  output  32  faulting req_addr

Behaviour:
- Reset: state IDLE; load_valid, load_data, load_rd, exc_valid, exc_cause and fault_addr all 0. While rst is high: op_code 011, rwaddr 0, wdata 0.
- stall = pipe_stall in all states.
- FSM IDLE:
  - req_ready = !pipe_stall.
  - Request is accepted when req_valid & req_ready.
  - An accepted legal request drives op_code/rwaddr/wdata combinationally in the same cycle; the memory samples them at the next edge.
  - op_code = {req_store, size}: size 00 for funct3[1:0]=00, 01 for 01, and 10 for a load word; a store word is 111.
  - rwaddr = req_addr[ADDR_W-1:0]; wdata = req_wdata.
  - In every other IDLE cycle op_code = 011.
- Legality check, evaluated on acceptance, priority bad op > misaligned > range:
  - bad op: req_load & req_store both high; load funct3 in {011,110,111}; store funct3 >= 011.
  - misaligned: half access with addr[0]=1; word access with addr[1:0] != 00.
  - range: req_addr[31:ADDR_W] != 0.
- An illegal request issues no access (op_code 011). At the next edge: exc_valid=1, exc_cause set, fault_addr=req_addr; the FSM stays in IDLE.
- Legal store: completes in the acceptance cycle; the FSM stays IDLE and no load_valid is produced.
- Legal load: at the edge, register funct3, addr[1:0] and req_rd; go to WAIT.
- FSM WAIT:
  - req_ready=0; op_code=011.
  - If pipe_stall=1: remain in WAIT (memory holds rdata).
  - Otherwise, at the edge: shift rdata right by 8*offset, then byte/half sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes rdata unchanged. Register the result into load_data, set load_rd and load_valid=1, and return to IDLE.
- Latency and throughput: load accepted in cycle N gives load_valid in cycle N+2 with no stall. Maximum throughput is one load per 2 cycles; stores can issue every cycle.
- load_valid and exc_valid are single-cycle pulses; load_data and load_rd hold their values until the next load completes.
- Reset asserted in WAIT: the pending load is discarded and no load_valid is produced.
- req_valid while pipe_stall=1: not accepted; no access, no exception.

Test Plan:
- Reset, then SW addr 0x0000_07FC data 0x0000_0001 followed by LW 0x7FC, rd=5 -> op_code 111 then 010; load_valid 2 cycles after the LW with load_data 0x0000_0001, load_rd 5.
- SB 0x0000_1BF9 data 0x0000_0080, then LB and LBU at the same address -> rwaddr 0x1BF9, op_code 100; LB returns 0xFFFF_FF80, LBU returns 0x0000_0080.
- SH 0x0000_07FE data 0x0000_8001, then LH and LHU -> op_code 101; LH returns 0xFFFF_8001, LHU returns 0x0000_8001.
- LW 0x0000_0002 -> op_code stays 011; next cycle exc_valid=1, exc_cause 01, fault_addr 0x2. LW 0x0000_4000 -> exc_cause 10. req_load & req_store both high -> exc_cause 11.
- LW accepted, then pipe_stall=1 for 3 cycles in WAIT -> stall=1, req_ready=0, no load_valid; load_valid in the cycle after stall releases, with the correct data.
- rst asserted while in WAIT -> no load_valid afterwards; all registered outputs 0; the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_port.sv
// MEM-stage initiator for the 16 KB data memory: issues load/store accesses, flags illegal
// requests and returns aligned, extended load results tagged with the destination register.
module lsu_mem_port #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  input  logic              pipe_stall,
  output logic              req_ready,
  output logic [2:0]        op_code,
  output logic [ADDR_W-1:0] rwaddr,
  output logic [31:0]       wdata,
  output logic              stall,
  input  logic [31:0]       rdata,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic [4:0]        load_rd,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [31:0]       fault_addr
);

  localparam logic [2:0] OpIdle = 3'b011;

  typedef enum logic {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        load_valid_q, exc_valid_q;
  logic [31:0] load_data_q, fault_addr_q;
  logic [4:0]  load_rd_q;
  logic [1:0]  exc_cause_q;

  logic        bad_op, misaligned, out_of_range, accept, issue;
  logic [1:0]  cause;
  logic [15:0] lo_half;
  logic [31:0] ext_data;

  assign stall     = pipe_stall;
  assign req_ready = (state_q == StIdle) && !pipe_stall;
  assign accept    = req_valid && req_ready && !rst;

  always_comb begin
    bad_op       = (req_load && req_store) ||
                   (req_load && (req_funct3 inside {3'b011, 3'b110, 3'b111})) ||
                   (req_store && (req_funct3 >= 3'b011));
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = |req_addr[31:ADDR_W];
    if (bad_op)            cause = 2'b11;
    else if (misaligned)   cause = 2'b01;
    else if (out_of_range) cause = 2'b10;
    else                   cause = 2'b00;
  end

  assign issue = accept && (cause == 2'b00) && (req_load || req_store);

  always_comb begin
    state_d = state_q;
    op_code = OpIdle;
    rwaddr  = '0;
    wdata   = '0;
    case (state_q)
      StIdle: begin
        if (issue) begin
          if (req_store) begin
            op_code = (req_funct3[1:0] == 2'b10) ? 3'b111 : {1'b1, req_funct3[1:0]};
          end else begin
            op_code = {1'b0, req_funct3[1:0]};
            state_d = StWait;
          end
          rwaddr = req_addr[ADDR_W-1:0];
          wdata  = req_wdata;
        end
      end
      StWait: begin
        if (!pipe_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory returns the whole aligned word; bring the addressed lane down to bit 0.
  assign lo_half = 16'(rdata >> {off_q, 3'b000});

  always_comb begin
    case (f3_q)
      3'b000:  ext_data = {{24{lo_half[7]}}, lo_half[7:0]};
      3'b001:  ext_data = {{16{lo_half[15]}}, lo_half};
      3'b100:  ext_data = {24'h0, lo_half[7:0]};
      3'b101:  ext_data = {16'h0, lo_half};
      default: ext_data = rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      f3_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      load_valid_q <= 1'b0;
      exc_valid_q  <= 1'b0;
      if (accept && (cause != 2'b00)) begin
        exc_valid_q  <= 1'b1;
        exc_cause_q  <= cause;
        fault_addr_q <= req_addr;
      end
      if (issue && req_load) begin
        f3_q  <= req_funct3;
        off_q <= req_addr[1:0];
        rd_q  <= req_rd;
      end
      if ((state_q == StWait) && !pipe_stall) begin
        load_valid_q <= 1'b1;
        load_data_q  <= ext_data;
        load_rd_q    <= rd_q;
      end
    end
  end

  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign load_rd    = load_rd_q;
  assign exc_valid  = exc_valid_q;
  assign exc_cause  = exc_cause_q;
  assign fault_addr = fault_addr_q;

endmodule
